// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   localparam int unsigned WORD_BYTES        = 4;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage : fetch_pkg

// File: rtl/pc_range_chk.sv
// Combinational legality check of a fetch byte address: word aligned and
// inside [BASE_ADDR, BASE_ADDR + WORD_BYTES*(MEMORY_DEPTH-1)], unsigned.
module pc_range_chk
   import fetch_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           MEMORY_DEPTH = 64,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
   input  logic [DATA_WIDTH-1:0] i_addr,
   output logic                  o_legal_c
);

   localparam logic [DATA_WIDTH-1:0] LAST_ADDR =
      BASE_ADDR + DATA_WIDTH'(WORD_BYTES * (MEMORY_DEPTH - 1));

   logic w_aligned;
   logic w_above_base;
   logic w_below_last;

   assign w_aligned    = (i_addr[1:0] == 2'b00);
   assign w_above_base = (i_addr >= BASE_ADDR);
   assign w_below_last = (i_addr <= LAST_ADDR);
   assign o_legal_c    = w_aligned & w_above_base & w_below_last;

endmodule : pc_range_chk

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the single-cycle ROM and
// hands instruction + PC downstream over valid/ready. Handles run/stop,
// redirects and range/alignment faults.
// Optional FETCH_PERF_CNT_EN adds a saturating accepted-handshake counter.
module rom_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned           MEMORY_DEPTH = 64,
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_addr_i,
   output logic [DATA_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] instr_pc_o,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic                  fault_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_count_o,
   input  logic                  count_clr_i
`endif
);

   fetch_state_e          r_state;
   fetch_state_e          w_state_nxt;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] w_pc_nxt;
   logic [DATA_WIDTH-1:0] r_instr;
   logic [DATA_WIDTH-1:0] r_instr_pc;
   logic                  r_valid;
   logic                  w_valid_nxt;
   logic                  r_fault;
   logic                  w_fault_nxt;
   logic                  w_cap;
   logic                  w_accept;
   logic                  w_pc_legal;
   logic                  w_redir_legal;

   pc_range_chk #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MEMORY_DEPTH (MEMORY_DEPTH),
      .BASE_ADDR    (BASE_ADDR)
   ) u_pc_chk (
      .i_addr    (r_pc),
      .o_legal_c (w_pc_legal)
   );

   pc_range_chk #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MEMORY_DEPTH (MEMORY_DEPTH),
      .BASE_ADDR    (BASE_ADDR)
   ) u_redir_chk (
      .i_addr    (redirect_addr_i),
      .o_legal_c (w_redir_legal)
   );

   assign w_accept = r_valid & instr_ready_i;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, next PC/valid/fault and capture strobe; redirect overrides all.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_valid_nxt = r_valid;
      w_fault_nxt = r_fault;
      w_cap       = 1'b0;

      if (redirect_i) begin
         w_valid_nxt = 1'b0;
         w_pc_nxt    = redirect_addr_i;
         if (w_redir_legal) begin
            w_fault_nxt = 1'b0;
            w_state_nxt = run_i ? FETCH : IDLE;
         end else begin
            w_fault_nxt = 1'b1;
            w_state_nxt = FAULT;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (run_i) begin
                  if (w_pc_legal) begin
                     w_state_nxt = FETCH;
                  end else begin
                     w_state_nxt = FAULT;
                     w_fault_nxt = 1'b1;
                  end
               end
            end
            FETCH: begin
               if (!run_i) begin
                  w_state_nxt = IDLE;
               end else if (!w_pc_legal) begin
                  w_state_nxt = FAULT;
                  w_fault_nxt = 1'b1;
               end else if (!r_valid || instr_ready_i) begin
                  w_cap    = 1'b1;
                  w_pc_nxt = r_pc + DATA_WIDTH'(WORD_BYTES);
               end
            end
            FAULT: begin
               w_state_nxt = FAULT;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase

         if (w_cap) begin
            w_valid_nxt = 1'b1;
         end else if (w_accept) begin
            w_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc       <= BASE_ADDR;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_valid <= w_valid_nxt;
         r_fault <= w_fault_nxt;
         if (w_cap) begin
            r_instr    <= rom_data_i;
            r_instr_pc <= r_pc;
         end
      end
   end

   assign rom_addr_o    = r_pc;
   assign instr_o       = r_instr;
   assign instr_pc_o    = r_instr_pc;
   assign instr_valid_o = r_valid;
   assign fault_o       = r_fault;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_count;

   // Saturating count of accepted handshakes; clear has priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_count <= '0;
      end else if (count_clr_i) begin
         r_fetch_count <= '0;
      end else if (w_accept && (r_fetch_count != 32'hFFFF_FFFF)) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign fetch_count_o = r_fetch_count;
`endif

endmodule : rom_fetch_ctrl

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: directed steps plus a random phase,
// checked each cycle against a transaction-level model with its own ROM.
module tb_rom_fetch_ctrl;

   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int unsigned DEPTH = 64;
   localparam int M_STOP = 0;
   localparam int M_RUN  = 1;
   localparam int M_FLT  = 2;

   logic        clk;
   logic        reset;
   logic        run_i;
   logic        redirect_i;
   logic [31:0] redirect_addr_i;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic        fault_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_o;
   logic        count_clr_i;
   logic [31:0] m_cnt;
`endif

   logic [31:0] rom [DEPTH];
   logic [31:0] w_off;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   logic        m_valid;
   logic        m_fault;

   rom_fetch_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .run_i           (run_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .rom_addr_o      (rom_addr_o),
      .rom_data_i      (rom_data_i),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .fault_o         (fault_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count_o   (fetch_count_o),
      .count_clr_i     (count_clr_i)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle combinational ROM
   always_comb begin
      w_off = rom_addr_o - BASE;
      if (w_off < 32'd256) rom_data_i = rom[w_off[7:2]];
      else                 rom_data_i = 32'hDEAD_BEEF;
   end

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a >= BASE) && ((a - BASE) / 4 < DEPTH);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_STOP;
      m_pc    = BASE;
      m_instr = 0;
      m_ipc   = 0;
      m_valid = 0;
      m_fault = 0;
`ifdef FETCH_PERF_CNT_EN
      m_cnt   = 0;
`endif
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_next();
      bit accept;
      bit captured;
      accept   = m_valid && instr_ready_i;
      captured = 0;
`ifdef FETCH_PERF_CNT_EN
      if (count_clr_i)                      m_cnt = 0;
      else if (accept && m_cnt != '1)       m_cnt = m_cnt + 1;
`endif
      if (redirect_i) begin
         m_valid = 0;
         m_pc    = redirect_addr_i;
         if (legal(redirect_addr_i)) begin
            m_fault = 0;
            m_mode  = run_i ? M_RUN : M_STOP;
         end else begin
            m_fault = 1;
            m_mode  = M_FLT;
         end
      end else begin
         if (m_mode == M_STOP && run_i) begin
            if (legal(m_pc)) m_mode = M_RUN;
            else begin m_mode = M_FLT; m_fault = 1; end
         end else if (m_mode == M_RUN) begin
            if (!run_i) m_mode = M_STOP;
            else if (!legal(m_pc)) begin m_mode = M_FLT; m_fault = 1; end
            else if (!m_valid || instr_ready_i) begin
               m_instr  = rom[(m_pc - BASE) / 4];
               m_ipc    = m_pc;
               m_valid  = 1;
               m_pc     = m_pc + 4;
               captured = 1;
            end
         end
         if (!captured && accept) m_valid = 0;
      end
   endtask

   task automatic check_all();
      chk("rom_addr", rom_addr_o, m_pc);
      chk("instr", instr_o, m_instr);
      chk("instr_pc", instr_pc_o, m_ipc);
      chk("valid", 32'(instr_valid_o), 32'(m_valid));
      chk("fault", 32'(fault_o), 32'(m_fault));
`ifdef FETCH_PERF_CNT_EN
      chk("count", fetch_count_o, m_cnt);
`endif
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic redirect_to(input logic [31:0] a);
      redirect_i      = 1;
      redirect_addr_i = a;
      step();
      redirect_i      = 0;
   endtask

   initial begin
      logic [31:0] prog [5];
      int          sel;
      prog[0] = 32'h2008ffff;
      prog[1] = 32'h20090010;
      prog[2] = 32'h200a000a;
      prog[3] = 32'h200b0019;
      prog[4] = 32'h012a8020;
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = (i < 5) ? prog[i] : $urandom;

      reset           = 0;
      run_i           = 0;
      redirect_i      = 0;
      redirect_addr_i = 0;
      instr_ready_i   = 0;
`ifdef FETCH_PERF_CNT_EN
      count_clr_i     = 0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1;

      // Streaming from reset at full rate
      run_i         = 1;
      instr_ready_i = 1;
      step();
      step();
      chk("first_instr", instr_o, 32'h2008ffff);
      chk("first_pc", instr_pc_o, 32'h0040_0000);
      step();
      chk("second_instr", instr_o, 32'h20090010);
      chk("second_pc", instr_pc_o, 32'h0040_0004);

      // Stall holds everything
      instr_ready_i = 0;
      repeat (3) step();
      chk("stall_instr", instr_o, 32'h20090010);
      chk("stall_addr", rom_addr_o, 32'h0040_0008);
      instr_ready_i = 1;
      step();
      chk("post_stall", instr_o, 32'h200a000a);

      // Redirect during stall flushes then fetches target
      instr_ready_i = 0;
      redirect_to(32'h0040_0010);
      chk("redir_flush", 32'(instr_valid_o), 32'd0);
      step();
      chk("redir_instr", instr_o, 32'h012a8020);
      chk("redir_pc", instr_pc_o, 32'h0040_0010);

      // Illegal redirects fault; a legal one recovers
      instr_ready_i = 1;
      redirect_to(32'h0040_0002);
      chk("misalign_fault", 32'(fault_o), 32'd1);
      repeat (2) step();
      redirect_to(32'h0040_0100);
      chk("range_fault", 32'(fault_o), 32'd1);
      step();
      redirect_to(32'h0040_0000);
      chk("recover_fault", 32'(fault_o), 32'd0);
      step();
      chk("recover_instr", instr_o, 32'h2008ffff);

      // Run off the end of the ROM
      repeat (66) step();
      chk("last_pc", instr_pc_o, 32'h0040_00FC);
      chk("end_fault", 32'(fault_o), 32'd1);
      chk("end_valid", 32'(instr_valid_o), 32'd0);
      chk("end_addr", rom_addr_o, 32'h0040_0100);

`ifdef FETCH_PERF_CNT_EN
      count_clr_i = 1;
      redirect_to(32'h0040_0000);
      count_clr_i = 0;
      step();
      repeat (5) step();
      chk("count5", fetch_count_o, 32'd5);
      count_clr_i = 1;
      step();
      count_clr_i = 0;
      chk("count_clr", fetch_count_o, 32'd0);
`endif

      // Random phase
      redirect_to(32'h0040_0000);
      for (int c = 0; c < 600; c++) begin
         run_i         = ($urandom_range(0, 9) != 0);
         instr_ready_i = ($urandom_range(0, 3) != 0);
         redirect_i    = ($urandom_range(0, 19) == 0);
         sel           = $urandom_range(0, 9);
         if (sel < 7)       redirect_addr_i = BASE + 4 * $urandom_range(0, DEPTH - 1);
         else if (sel == 7) redirect_addr_i = BASE + ($urandom_range(0, 255) | 1);
         else if (sel == 8) redirect_addr_i = BASE + 256 + 4 * $urandom_range(0, 15);
         else               redirect_addr_i = $urandom;
`ifdef FETCH_PERF_CNT_EN
         count_clr_i = ($urandom_range(0, 29) == 0);
`endif
         step();
      end
      redirect_i = 0;
`ifdef FETCH_PERF_CNT_EN
      count_clr_i = 0;
`endif

      // Asynchronous reset mid-stream
      run_i         = 1;
      instr_ready_i = 1;
      redirect_to(32'h0040_0020);
      repeat (3) step();
      #2 reset = 0;
      #1;
      chk("areset_instr", instr_o, 32'd0);
      chk("areset_pc", instr_pc_o, 32'd0);
      chk("areset_valid", 32'(instr_valid_o), 32'd0);
      chk("areset_fault", 32'(fault_o), 32'd0);
      chk("areset_addr", rom_addr_o, 32'h0040_0000);
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      reset = 1;
      repeat (4) step();
      chk("post_reset_instr", instr_o, 32'h200a000a);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_rom_fetch_ctrl

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read instruction ROM (MEMORY_DEPTH words, byte addresses from BASE_ADDR). It owns the program counter, drives the ROM address and registers the returned word. It presents instruction + PC to the downstream decode stage over a valid/ready handshake. It also handles run/stop, branch/jump redirects, and out-of-range/misaligned fetch faults.

Parameters:
MEMORY_DEPTH, 64, number of 32-bit words in the ROM
DATA_WIDTH, 32, instruction and address width
BASE_ADDR, 32'h0040_0000, byte address of ROM word 0; reset PC

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run_i  input  1  1 = fetching enabled; 0 = stop issuing new fetches
redirect_i  input  1  one-cycle pulse: load redirect_addr_i into PC and flush
redirect_addr_i  input  DATA_WIDTH  new fetch byte address
rom_addr_o  output  DATA_WIDTH  byte address to ROM Address_i (= pc_q)
rom_data_i  input  DATA_WIDTH  ROM Instruction_o (combinational, same cycle)
instr_o  output  DATA_WIDTH  registered instruction
instr_pc_o  output  DATA_WIDTH  byte address instr_o was fetched from
instr_valid_o  output  1  instr_o/instr_pc_o valid
instr_ready_i  input  1  downstream accepts when valid & ready
fault_o  output  1  sticky fetch fault

Behaviour:
- Reset (reset=0, async): pc_q=BASE_ADDR, instr_o=0, instr_pc_o=0, instr_valid_o=0, fault_o=0, state=IDLE. rom_addr_o=pc_q at all times.
- States: IDLE, FETCH, FAULT.
- IDLE: no capture. Go to FETCH when run_i=1 and pc_q is legal; go to FAULT if run_i=1 and pc_q is illegal.
- Legal PC: pc_q[1:0]==0 and BASE_ADDR <= pc_q <= BASE_ADDR + 4*(MEMORY_DEPTH-1). Compare unsigned at DATA_WIDTH.
- FETCH, capture condition: cap = !instr_valid_o | instr_ready_i.
  - On cap: instr_o<=rom_data_i, instr_pc_o<=pc_q, instr_valid_o<=1, pc_q<=pc_q+4 (wraps modulo 2^DATA_WIDTH; the range check catches it).
  - Latency: word at PC appears on instr_o one cycle after pc_q presents it.
  - Throughput: 1 instr/cycle while ready=1.
  - valid & !ready: all outputs and pc_q hold (stall, no dropped or duplicated words).
- Accept without new capture (valid & ready, but run_i=0 or in IDLE/FAULT): instr_valid_o<=0.
- run_i falls in FETCH: go to IDLE next cycle; no capture that cycle. A pending valid word stays until accepted.
- End of ROM: when pc_q becomes illegal in FETCH, take no capture and go to FAULT with fault_o<=1. The last legal word still drains normally.
- FAULT: no capture. fault_o stays 1 until reset or a legal redirect.
- Redirect (highest priority, any state):
  - Next cycle: instr_valid_o<=0 (flush, even if ready=0); pc_q<=redirect_addr_i; no capture that cycle.
  - If redirect_addr_i is legal: fault_o<=0, state<=(run_i ? FETCH : IDLE).
  - If illegal: fault_o<=1, state<=FAULT.
  - Redirect coinciding with a handshake: the accept completes, and the flush still applies.
- Reset mid-operation: immediate return to reset values; no partial state survives.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output fetch_count_o[31:0] and input count_clr_i.
  - Counter increments on every accepted handshake (valid & ready) and saturates at 32'hFFFF_FFFF.
  - Resets to 0 on reset or count_clr_i; clear wins over increment.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package fetch_pkg: state enum fetch_state_e {IDLE, FETCH, FAULT}, localparam WORD_BYTES=4, default BASE_ADDR constant.
- One natural sub-module, pc_range_chk: combinational legality check (alignment + bounds) of an address given BASE_ADDR/MEMORY_DEPTH. It is instantiated twice, for pc_q and for redirect_addr_i.
- Bench uses the real ROM with program words 0x2008ffff, 0x20090010, 0x200a000a, 0x200b0019, 0x012a8020, …

Test Plan:
- Reset release, run_i=1, ready=1 → cycle+1: instr_o=0x2008ffff, instr_pc_o=0x0040_0000. Next cycles 0x20090010@0x400004, 0x200a000a@0x400008, one per cycle.
- ready=0 for 3 cycles while valid with 0x20090010@0x400004 → outputs stable, rom_addr_o=0x400008. After ready=1, next word is 0x200a000a (no skip/dup).
- Redirect to 0x0040_0010 while valid & ready=0 → next cycle valid=0. Following cycle instr_o=0x012a8020, instr_pc_o=0x400010.
- Redirect to 0x0040_0002 (misaligned) or 0x0040_0100 (past 64 words) → fault_o=1, valid=0, no captures. Redirect to 0x400000 → fault_o=0, fetch resumes with 0x2008ffff.
- Run to the last word (0x4000FC) → word delivered, then fault_o=1 and no capture of 0x400100. Also: async reset asserted mid-stream → all outputs 0 and pc_q=0x400000 immediately.
- With FETCH_PERF_CNT_EN: 5 accepted handshakes → fetch_count_o=5. Assert count_clr_i together with a handshake → fetch_count_o=0.
